ball_motion_engine: RTL and testbench

//  Per-ball motion engine for the billiard table. It takes a cue shot through a

---
 rtl/ball_motion_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
// rtl/ball_motion_engine.sv - per-ball fixed-point motion integrator with rest/pocket state machine
module ball_motion_engine #(
    parameter int FRAC_BITS   = 6,
    parameter int SPEED_W     = 12,
    parameter int INIT_X      = 280,
    parameter int INIT_Y      = 185,
    parameter int MIN_X       = 48,
    parameter int MAX_X       = 560,
    parameter int MIN_Y       = 32,
    parameter int MAX_Y       = 416,
    parameter int MAX_SPEED   = 230,
    parameter int FRICTION    = 1,
    parameter int MIN_SPEED   = 2,
    parameter int STOP_FRAMES = 10,
    parameter int HOLE_FRAMES = 3
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      shotValid,
    output logic                      shotReady,
    input  logic signed [SPEED_W-1:0] shotXSpeed,
    input  logic signed [SPEED_W-1:0] shotYSpeed,
    input  logic                      collisionBorder,
    input  logic [3:0]                hitEdgeCode,
    input  logic                      collisionBall,
    input  logic signed [SPEED_W-1:0] xSpeedNew,
    input  logic signed [SPEED_W-1:0] ySpeedNew,
    input  logic                      inHole,
    input  logic                      respawn,
    output logic signed [10:0]        topLeftX,
    output logic signed [10:0]        topLeftY,
    output logic signed [SPEED_W-1:0] xSpeed,
    output logic signed [SPEED_W-1:0] ySpeed,
    output logic [1:0]                state,
    output logic                      stopped,
    output logic                      killBall
);

    localparam int POS_W  = 11 + FRAC_BITS + 1;
    localparam int STOP_W = $clog2(STOP_FRAMES + 1);
    localparam int HOLE_W = $clog2(HOLE_FRAMES + 1);

    localparam logic signed [SPEED_W-1:0] MAX_S     = MAX_SPEED[SPEED_W-1:0];
    localparam logic signed [SPEED_W-1:0] NEG_MAX_S = -MAX_S;
    localparam logic signed [SPEED_W-1:0] MIN_S     = MIN_SPEED[SPEED_W-1:0];
    localparam logic signed [SPEED_W-1:0] FRIC_S    = FRICTION[SPEED_W-1:0];

    localparam logic signed [POS_W-1:0] INIT_X_P = POS_W'(INIT_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] INIT_Y_P = POS_W'(INIT_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] MIN_X_P  = POS_W'(MIN_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] MAX_X_P  = POS_W'(MAX_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] MIN_Y_P  = POS_W'(MIN_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] MAX_Y_P  = POS_W'(MAX_Y << FRAC_BITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROLLING = 2'd1,
        S_DEAD    = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [POS_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [SPEED_W-1:0]  x_speed_q, x_speed_d, y_speed_q, y_speed_d;
    logic [STOP_W-1:0]          stop_ctr_q, stop_ctr_d;
    logic [HOLE_W-1:0]          hole_ctr_q, hole_ctr_d;
    logic                       ball_done_q, ball_done_d;
    logic                       border_done_q, border_done_d;
    logic                       kill_ball_q, kill_ball_d;

    logic signed [SPEED_W-1:0]  vx, vy, sat_x_new, sat_y_new;
    logic signed [POS_W-1:0]    nx, ny;

    function automatic logic signed [SPEED_W-1:0] sat_speed(input logic signed [SPEED_W-1:0] v);
        if (v > MAX_S)
            return MAX_S;
        else if (v < NEG_MAX_S)
            return NEG_MAX_S;
        else
            return v;
    endfunction

    function automatic logic signed [SPEED_W-1:0] abs_speed(input logic signed [SPEED_W-1:0] v);
        return v[SPEED_W-1] ? -v : v;
    endfunction

    // Speeds below MIN_SPEED snap to zero, otherwise decay toward zero by FRICTION.
    function automatic logic signed [SPEED_W-1:0] apply_friction(input logic signed [SPEED_W-1:0] v);
        if (abs_speed(v) < MIN_S)
            return '0;
        else if (v[SPEED_W-1])
            return v + FRIC_S;
        else
            return v - FRIC_S;
    endfunction

    // Next-state, kinematics and event handling.
    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        x_speed_d     = x_speed_q;
        y_speed_d     = y_speed_q;
        stop_ctr_d    = stop_ctr_q;
        hole_ctr_d    = hole_ctr_q;
        ball_done_d   = startOfFrame ? 1'b0 : ball_done_q;
        border_done_d = startOfFrame ? 1'b0 : border_done_q;
        kill_ball_d   = 1'b0;
        sat_x_new     = sat_speed(xSpeedNew);
        sat_y_new     = sat_speed(ySpeedNew);
        vx            = x_speed_q;
        vy            = y_speed_q;
        nx            = pos_x_q;
        ny            = pos_y_q;

        case (state_q)
            S_IDLE: begin
                if (shotValid) begin
                    x_speed_d  = sat_speed(shotXSpeed);
                    y_speed_d  = sat_speed(shotYSpeed);
                    stop_ctr_d = '0;
                    hole_ctr_d = '0;
                    state_d    = S_ROLLING;
                end else if (collisionBall && (sat_x_new != '0 || sat_y_new != '0)) begin
                    // Struck by another ball while resting.
                    x_speed_d   = sat_x_new;
                    y_speed_d   = sat_y_new;
                    stop_ctr_d  = '0;
                    hole_ctr_d  = '0;
                    ball_done_d = !startOfFrame;
                    state_d     = S_ROLLING;
                end
            end

            S_ROLLING: begin
                if (startOfFrame) begin
                    nx = pos_x_q + POS_W'(x_speed_q);
                    ny = pos_y_q + POS_W'(y_speed_q);
                    vx = apply_friction(x_speed_q);
                    vy = apply_friction(y_speed_q);
                    if (nx < MIN_X_P) begin
                        nx = MIN_X_P;
                        vx = abs_speed(vx);
                    end else if (nx > MAX_X_P) begin
                        nx = MAX_X_P;
                        vx = -abs_speed(vx);
                    end
                    if (ny < MIN_Y_P) begin
                        ny = MIN_Y_P;
                        vy = abs_speed(vy);
                    end else if (ny > MAX_Y_P) begin
                        ny = MAX_Y_P;
                        vy = -abs_speed(vy);
                    end
                    pos_x_d    = nx;
                    pos_y_d    = ny;
                    x_speed_d  = vx;
                    y_speed_d  = vy;
                    stop_ctr_d = (x_speed_q == '0 && y_speed_q == '0) ? stop_ctr_q + 1'b1 : '0;
                    hole_ctr_d = inHole ? hole_ctr_q + 1'b1 : '0;
                    // Pocketing wins over coming to rest in the same frame.
                    if (hole_ctr_d == HOLE_W'(HOLE_FRAMES)) begin
                        state_d     = S_DEAD;
                        x_speed_d   = '0;
                        y_speed_d   = '0;
                        kill_ball_d = 1'b1;
                        stop_ctr_d  = '0;
                        hole_ctr_d  = '0;
                    end else if (stop_ctr_d == STOP_W'(STOP_FRAMES)) begin
                        state_d    = S_IDLE;
                        stop_ctr_d = '0;
                        hole_ctr_d = '0;
                    end
                end else begin
                    // Ball load first so the cushion sign forcing acts on the new speeds.
                    if (collisionBall && !ball_done_q) begin
                        vx          = sat_x_new;
                        vy          = sat_y_new;
                        ball_done_d = 1'b1;
                    end
                    if (collisionBorder && !border_done_q) begin
                        if (hitEdgeCode[0]) vy = abs_speed(vy);
                        if (hitEdgeCode[2]) vy = -abs_speed(vy);
                        if (hitEdgeCode[1]) vx = abs_speed(vx);
                        if (hitEdgeCode[3]) vx = -abs_speed(vx);
                        border_done_d = 1'b1;
                    end
                    x_speed_d = vx;
                    y_speed_d = vy;
                end
            end

            S_DEAD: begin
                if (respawn) begin
                    state_d    = S_IDLE;
                    pos_x_d    = INIT_X_P;
                    pos_y_d    = INIT_Y_P;
                    x_speed_d  = '0;
                    y_speed_d  = '0;
                    stop_ctr_d = '0;
                    hole_ctr_d = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= S_IDLE;
            pos_x_q       <= INIT_X_P;
            pos_y_q       <= INIT_Y_P;
            x_speed_q     <= '0;
            y_speed_q     <= '0;
            stop_ctr_q    <= '0;
            hole_ctr_q    <= '0;
            ball_done_q   <= 1'b0;
            border_done_q <= 1'b0;
            kill_ball_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            x_speed_q     <= x_speed_d;
            y_speed_q     <= y_speed_d;
            stop_ctr_q    <= stop_ctr_d;
            hole_ctr_q    <= hole_ctr_d;
            ball_done_q   <= ball_done_d;
            border_done_q <= border_done_d;
            kill_ball_q   <= kill_ball_d;
        end
    end

    assign topLeftX  = pos_x_q[POS_W-2:FRAC_BITS];
    assign topLeftY  = pos_y_q[POS_W-2:FRAC_BITS];
    assign xSpeed    = x_speed_q;
    assign ySpeed    = y_speed_q;
    assign state     = state_q;
    assign stopped   = (state_q == S_IDLE);
    assign shotReady = (state_q == S_IDLE);
    assign killBall  = kill_ball_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb/tb_ball_motion_engine.sv - directed self-checking bench for ball_motion_engine
module tb_ball_motion_engine;

    logic               clk = 1'b0;
    logic               resetN = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               shotValid = 1'b0;
    logic               shotReady;
    logic signed [11:0] shotXSpeed = '0;
    logic signed [11:0] shotYSpeed = '0;
    logic               collisionBorder = 1'b0;
    logic [3:0]         hitEdgeCode = '0;
    logic               collisionBall = 1'b0;
    logic signed [11:0] xSpeedNew = '0;
    logic signed [11:0] ySpeedNew = '0;
    logic               inHole = 1'b0;
    logic               respawn = 1'b0;
    logic signed [10:0] topLeftX, topLeftY;
    logic signed [11:0] xSpeed, ySpeed;
    logic [1:0]         state;
    logic               stopped;
    logic               killBall;

    int n_checks = 0;
    int n_fail   = 0;

    ball_motion_engine dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .shotValid(shotValid), .shotReady(shotReady),
        .shotXSpeed(shotXSpeed), .shotYSpeed(shotYSpeed),
        .collisionBorder(collisionBorder), .hitEdgeCode(hitEdgeCode),
        .collisionBall(collisionBall), .xSpeedNew(xSpeedNew), .ySpeedNew(ySpeedNew),
        .inHole(inHole), .respawn(respawn),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .xSpeed(xSpeed), .ySpeed(ySpeed),
        .state(state), .stopped(stopped), .killBall(killBall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b1;
        cyc();
        resetN = 1'b0;
    endtask

    task automatic shot(input int sx, input int sy);
        shotXSpeed = 12'(sx);
        shotYSpeed = 12'(sy);
        shotValid  = 1'b1;
        cyc();
        shotValid  = 1'b0;
    endtask

    initial begin
        cyc();
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_x", int'(topLeftX), 280);
        check("rst_y", int'(topLeftY), 185);
        check("rst_xspd", int'(xSpeed), 0);
        check("rst_stopped", int'(stopped), 1);
        check("rst_ready", int'(shotReady), 1);
        check("rst_kill", int'(killBall), 0);

        // Single frame after a (100,0) shot.
        shot(100, 0);
        check("t1_state_acc", int'(state), 1);
        check("t1_ready_low", int'(shotReady), 0);
        frame();
        check("t1_x", int'(topLeftX), 281);
        check("t1_xspd", int'(xSpeed), 99);
        check("t1_state", int'(state), 1);

        // Reset mid-roll.
        do_reset();
        check("t6_state", int'(state), 0);
        check("t6_x", int'(topLeftX), 280);
        check("t6_y", int'(topLeftY), 185);
        check("t6_xspd", int'(xSpeed), 0);

        // Slow shot decays to rest after STOP_FRAMES zero-speed frames.
        shot(3, 0);
        frame(); check("t2_v1", int'(xSpeed), 2);
        frame(); check("t2_v2", int'(xSpeed), 1);
        frame(); check("t2_v3", int'(xSpeed), 0);
        for (int f = 4; f <= 12; f++) frame();
        check("t2_state_f12", int'(state), 1);
        frame();
        check("t2_state_f13", int'(state), 0);
        check("t2_x", int'(topLeftX), 280);
        check("t2_ready", int'(shotReady), 1);
        check("t2_stopped", int'(stopped), 1);

        // Left cushion held several cycles.
        shot(-200, 0);
        collisionBorder = 1'b1;
        hitEdgeCode     = 4'b0010;
        repeat (5) cyc();
        collisionBorder = 1'b0;
        check("t3_xspd", int'(xSpeed), 200);
        check("t3_yspd", int'(ySpeed), 0);
        frame();
        check("t3_fric", int'(xSpeed), 199);

        // Ball load plus corner (top+right) in one cycle, then second load ignored.
        collisionBall   = 1'b1;
        xSpeedNew       = 12'sd50;
        ySpeedNew       = -12'sd60;
        collisionBorder = 1'b1;
        hitEdgeCode     = 4'b1001;
        cyc();
        collisionBorder = 1'b0;
        check("corner_x", int'(xSpeed), -50);
        check("corner_y", int'(ySpeed), 60);
        xSpeedNew = 12'sd70;
        cyc();
        collisionBall = 1'b0;
        check("once_per_frame", int'(xSpeed), -50);

        // Saturation of collision load and of shot.
        frame();
        collisionBall = 1'b1;
        xSpeedNew     = -12'sd900;
        ySpeedNew     = 12'sd0;
        cyc();
        collisionBall = 1'b0;
        check("t4_sat_new", int'(xSpeed), -230);
        do_reset();
        shot(1000, 0);
        check("t4_sat_shot", int'(xSpeed), 230);

        // Top clamp: ySpeed -230 reaches MIN_Y on frame 48.
        do_reset();
        shot(0, -230);
        for (int f = 1; f <= 47; f++) frame();
        check("clamp_pre_y", int'(topLeftY), 32);
        check("clamp_pre_v", int'(ySpeed), -183);
        frame();
        check("clamp_y", int'(topLeftY), 32);
        check("clamp_v", int'(ySpeed), 182);

        // Pocketing after three inHole frames, then respawn.
        do_reset();
        shot(50, 0);
        inHole = 1'b1;
        frame(); frame();
        check("t5_state_f2", int'(state), 1);
        check("t5_kill_f2", int'(killBall), 0);
        frame();
        inHole = 1'b0;
        check("t5_kill", int'(killBall), 1);
        check("t5_state", int'(state), 2);
        check("t5_xspd", int'(xSpeed), 0);
        check("t5_ready", int'(shotReady), 0);
        collisionBall = 1'b1;
        xSpeedNew     = 12'sd10;
        cyc();
        collisionBall = 1'b0;
        check("t5_kill_once", int'(killBall), 0);
        check("dead_ignore", int'(xSpeed), 0);
        check("dead_state", int'(state), 2);
        respawn = 1'b1;
        cyc();
        respawn = 1'b0;
        check("resp_state", int'(state), 0);
        check("resp_x", int'(topLeftX), 280);
        check("resp_y", int'(topLeftY), 185);

        // IDLE: zero-speed ball hit ignored, non-zero hit starts rolling.
        collisionBall = 1'b1;
        xSpeedNew     = 12'sd0;
        ySpeedNew     = 12'sd0;
        cyc();
        check("idle_zero_hit", int'(state), 0);
        xSpeedNew = 12'sd40;
        cyc();
        collisionBall = 1'b0;
        check("idle_hit_state", int'(state), 1);
        check("idle_hit_xspd", int'(xSpeed), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
